// File: rtl/mem_req_sram_bridge.sv
// mem_req_sram_bridge: in-order request FIFO replaying to a grant/stall SRAM.
// Read data is returned in request order after a fixed RD_LAT pipe.
// Ports: clk, rst (sync, active-high); mem_req/mem_write/mem_addr/mem_wdata
//   upstream requests; mem_rdata_vld/mem_rdata in-order read return;
//   sram_cs/we/addr/wdata + sram_gnt/sram_rdata SRAM side;
//   overflow (sticky) / overflow_clr; busy; fifo_level occupancy.
// Option: MEM_BRIDGE_BYPASS_EN issues to the SRAM in the request cycle
//   when the FIFO is empty.
`timescale 1ns/1ps
module mem_req_sram_bridge #(
  parameter int MEM_AW     = 16,
  parameter int MEM_DW     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_req,
  input  logic                          mem_write,
  input  logic [MEM_AW-1:0]             mem_addr,
  input  logic [MEM_DW-1:0]             mem_wdata,
  output logic                          mem_rdata_vld,
  output logic [MEM_DW-1:0]             mem_rdata,
  output logic                          sram_cs,
  output logic                          sram_we,
  output logic [MEM_AW-1:0]             sram_addr,
  output logic [MEM_DW-1:0]             sram_wdata,
  input  logic                          sram_gnt,
  input  logic [MEM_DW-1:0]             sram_rdata,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } req_t;

  req_t              fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [RD_LAT:0]   pipe_sh;
  logic              vld_q, vld_d;
  logic [MEM_DW-1:0] rdata_q, rdata_d;

  logic empty, full, push, pop, drop, acc, rd_acc;
  req_t in_req, head, issue;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == LW'(FIFO_DEPTH));
  assign in_req = '{we: mem_write, addr: mem_addr, wdata: mem_wdata};
  assign head   = fifo_q[rptr_q];
  assign pop    = !empty && sram_gnt;

`ifdef MEM_BRIDGE_BYPASS_EN
  // Empty FIFO: present the incoming request directly; it only
  // enters the FIFO if the SRAM stalls it.
  assign sram_cs = !empty || mem_req;
  assign issue   = empty ? in_req : head;
  assign push    = mem_req && !(empty && sram_gnt) && (!full || pop);
  assign drop    = mem_req && !(empty && sram_gnt) && full && !pop;
`else
  assign sram_cs = !empty;
  assign issue   = head;
  assign push    = mem_req && (!full || pop);
  assign drop    = mem_req && full && !pop;
`endif

  assign sram_we    = issue.we;
  assign sram_addr  = issue.addr;
  assign sram_wdata = issue.wdata;

  assign acc    = sram_cs && sram_gnt;
  assign rd_acc = acc && !issue.we;

  always_comb begin
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);
    cnt_d   = cnt_q + LW'(push) - LW'(pop);
    ovf_d   = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    pipe_sh = {pipe_q, rd_acc};
    pipe_d  = pipe_sh[RD_LAT-1:0];
    vld_d   = pipe_q[RD_LAT-1];
    rdata_d = vld_d ? sram_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= in_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pipe_q  <= '0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pipe_q  <= pipe_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_rdata_vld = vld_q;
  assign mem_rdata     = rdata_q;
  assign overflow      = ovf_q;
  assign fifo_level    = cnt_q;
  // Return register included so busy drops the cycle after the last pulse.
  assign busy          = !empty || (|pipe_q) || vld_q;

endmodule

// File: tb/tb_mem_req_sram_bridge.sv
// Bench for mem_req_sram_bridge: queue-based reference model plus
// SRAM model, checked every cycle, with directed literal checks.
`timescale 1ns/1ps
module tb_mem_req_sram_bridge;
  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 2;
  localparam int LW     = $clog2(DEPTH) + 1;
`ifdef MEM_BRIDGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst;
  logic mem_req, mem_write, overflow_clr, sram_gnt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_rdata_vld, sram_cs, sram_we, overflow, busy;
  logic [DW-1:0] mem_rdata, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;
  logic [LW-1:0] fifo_level;

  mem_req_sram_bridge #(
    .MEM_AW(AW), .MEM_DW(DW), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_gnt(sram_gnt), .sram_rdata(sram_rdata),
    .overflow(overflow), .overflow_clr(overflow_clr),
    .busy(busy), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  function automatic logic [31:0] dflt(logic [15:0] a);
    return 32'hC0DE_0000 | {16'h0, a};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // SRAM model: samples the handshake mid-cycle, applies it on the edge.
  logic [31:0] smem [logic [15:0]];
  logic [31:0] rd_dly [RD_LAT];
  logic [15:0] wr_log [$];
  logic c_acc = 1'b0;
  logic c_we;
  logic [15:0] c_a;
  logic [31:0] c_d;

  assign sram_rdata = rd_dly[RD_LAT-1];

  always @(negedge clk) begin
    c_acc = sram_cs & sram_gnt;
    c_we  = sram_we;
    c_a   = sram_addr;
    c_d   = sram_wdata;
  end

  always @(posedge clk) begin
    logic [31:0] rv;
    rv = 32'hBAD0_BAD0;
    if (c_acc === 1'b1) begin
      if (c_we) begin
        smem[c_a] = c_d;
        wr_log.push_back(c_a);
      end else begin
        rv = smem.exists(c_a) ? smem[c_a] : dflt(c_a);
      end
    end
    rd_dly[0] <= rv;
    for (int i = 1; i < RD_LAT; i++) rd_dly[i] <= rd_dly[i-1];
  end

  // Reference model: request queue, memory image, list of due returns.
  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [31:0] d;
  } req_t;
  typedef struct {
    int          due;
    logic [31:0] d;
  } ret_t;

  req_t mq [$];
  ret_t mret [$];
  logic [31:0] mmem [logic [15:0]];
  bit m_ovf = 1'b0;
  logic [31:0] m_rdata = '0;
  bit started = 1'b0;

  function automatic req_t in_req();
    req_t r;
    r.we = mem_write;
    r.a  = mem_addr;
    r.d  = mem_wdata;
    return r;
  endfunction

  function automatic bit m_cs();
    return (mq.size() > 0) || (BYP && mem_req);
  endfunction

  function automatic req_t m_issue();
    if (mq.size() > 0) return mq[0];
    return in_req();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mret.delete();
      m_ovf   = 1'b0;
      m_rdata = '0;
      started = 1'b1;
    end else if (started) begin
      bit cs, pop, thru, push;
      req_t h;
      ret_t r;
      cs   = m_cs();
      h    = m_issue();
      pop  = (mq.size() > 0) && sram_gnt;
      thru = (mq.size() == 0) && cs && sram_gnt;
      if (cs && sram_gnt) begin
        if (h.we) mmem[h.a] = h.d;
        else begin
          r.due = cyc + RD_LAT + 1;
          r.d   = mmem.exists(h.a) ? mmem[h.a] : dflt(h.a);
          mret.push_back(r);
        end
      end
      push = mem_req && !thru && (mq.size() < DEPTH || pop);
      if (mem_req && !thru && !push) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(in_req());
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      bit ev, ecs;
      req_t h;
      ev = 1'b0;
      while (mret.size() > 0 && mret[0].due < cyc) void'(mret.pop_front());
      if (mret.size() > 0 && mret[0].due == cyc) begin
        ev = 1'b1;
        m_rdata = mret[0].d;
      end
      ecs = m_cs();
      h   = m_issue();
      chk("sram_cs", sram_cs, ecs);
      if (ecs) begin
        chk("sram_we", sram_we, h.we);
        chk("sram_addr", sram_addr, h.a);
        chk("sram_wdata", sram_wdata, h.d);
      end
      chk("fifo_level", fifo_level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, (mq.size() > 0) || (mret.size() > 0));
      chk("rdata_vld", mem_rdata_vld, ev);
      chk("rdata", mem_rdata, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_req = 1'b0;
    mem_write = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    overflow_clr = 1'b0;
  endtask

  task automatic req(bit w, logic [15:0] a, logic [31:0] d);
    mem_req = 1'b1;
    mem_write = w;
    mem_addr = a;
    mem_wdata = d;
  endtask

  initial begin
    int t0, lat, nv;
    bit found;
    rst = 1'b1;
    sram_gnt = 1'b0;
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("rst_level", fifo_level, 0);
    chk("rst_vld", mem_rdata_vld, 0);
    rst = 1'b0;
    sram_gnt = 1'b1;
    tick();

    // Write then read back through the SRAM.
    req(1'b1, 16'h0010, 32'hDEADBEEF);
    tick();
    idle();
    repeat (3) tick();
    t0 = cyc;
    req(1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    chk("cs_req_cycle", sram_cs, BYP);
    tick();
    idle();
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_rdata_vld) begin
        lat = cyc - t0;
        break;
      end
    end
    chk("rd_latency", lat, BYP ? RD_LAT + 1 : RD_LAT + 2);
    chk("rd_data", mem_rdata, 32'hDEADBEEF);
    tick();
    repeat (4) tick();

    // Five writes into a stalled SRAM: one dropped.
    sram_gnt = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 16'h0020 + 16'(i), 32'h1000 + i);
      tick();
    end
    req(1'b1, 16'h0025, 32'h1005);
    overflow_clr = 1'b1;
    @(negedge clk);
    chk("full_level", fifo_level, 4);
    chk("ovf_set", overflow, 1);
    tick();
    idle();
    overflow_clr = 1'b1;
    @(negedge clk);
    chk("ovf_set_beats_clr", overflow, 1);
    tick();
    overflow_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow, 0);
    sram_gnt = 1'b1;
    repeat (8) tick();
    chk("wr_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("wr_order", wr_log[i], 16'h0020 + 16'(i));

    // Push into a full FIFO while it pops.
    sram_gnt = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 16'h0030 + 16'(i), 32'h2000 + i);
      tick();
    end
    req(1'b1, 16'h0034, 32'h2004);
    sram_gnt = 1'b1;
    tick();
    idle();
    chk("full_pushpop_level", fifo_level, 4);
    chk("full_pushpop_ovf", overflow, 0);
    repeat (8) tick();
    chk("full_wr_count", wr_log.size(), 5);
    chk("full_wr_last", wr_log[4], 16'h0034);

    // Back-to-back reads.
    for (int a = 1; a <= 3; a++) begin
      req(1'b0, 16'(a), 32'h0);
      tick();
    end
    idle();
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_rdata_vld) begin
        found = 1'b1;
        break;
      end
    end
    chk("burst_start", found, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("burst_vld", mem_rdata_vld, 1);
      chk("burst_data", mem_rdata, dflt(16'(k + 1)));
    end
    @(negedge clk);
    chk("burst_end", mem_rdata_vld, 0);
    tick();
    repeat (4) tick();

    // Reset with reads in flight.
    req(1'b0, 16'h0005, 32'h0);
    tick();
    req(1'b0, 16'h0006, 32'h0);
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_rdata_vld) nv++;
    end
    chk("post_rst_vld", nv, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_level", fifo_level, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
